// File: rtl/nvdla_apb2csb_mt.sv
// APB-to-CSB bridge fanning one APB slave port out to NUM_TGT CSB targets.
// Handles non-posted write tracking, a response timeout and pslverr reporting.
module nvdla_apb2csb_mt #(
    parameter int unsigned NUM_TGT    = 2,
    parameter int unsigned CSB_AW     = 16,
    parameter int unsigned SEL_LSB    = 18,
    parameter int unsigned NPOSTED_WR = 1,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned TO_W       = 10
) (
    input  logic                    pclk,
    input  logic                    prstn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [31:0]             paddr,
    input  logic [31:0]             pwdata,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [NUM_TGT-1:0]      csb2tgt_valid,
    input  logic [NUM_TGT-1:0]      csb2tgt_ready,
    output logic [CSB_AW-1:0]       csb2tgt_addr,
    output logic [31:0]             csb2tgt_wdat,
    output logic                    csb2tgt_write,
    output logic                    csb2tgt_nposted,
    input  logic [NUM_TGT-1:0]      tgt2csb_valid,
    input  logic [32*NUM_TGT-1:0]   tgt2csb_data,
    input  logic [NUM_TGT-1:0]      tgt2csb_wr_complete
);

    localparam int unsigned SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam bit NPOSTED = (NPOSTED_WR != 0);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [NUM_TGT-1:0] ONE_HOT0 = NUM_TGT'(1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

    state_e              state_q;
    logic [SEL_W-1:0]    tgt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                skip_q;
    logic [31:0]         prdata_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [NUM_TGT-1:0]  valid_q;
    logic [CSB_AW-1:0]   addr_q;
    logic [31:0]         wdat_q;
    logic                write_q;

    logic [SEL_W-1:0]    sel;
    logic                in_range;
    logic                to_hit;
    logic                sel_ready;
    logic                sel_rvalid;
    logic                sel_wrc;
    logic [31:0]         sel_rdata;
    logic                unused_ok;

    assign sel      = paddr[SEL_LSB +: SEL_W];
    assign in_range = (32'(sel) < NUM_TGT);
    assign to_hit   = TO_EN && (to_cnt_q == TO_LAST);
    // Upper paddr bits and byte offset are not part of the CSB address.
    assign unused_ok = ^paddr;

    // Pick the handshake/response signals of the latched target.
    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_wrc    = 1'b0;
        sel_rdata  = 32'h0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt_q == SEL_W'(i)) begin
                sel_ready  = csb2tgt_ready[i];
                sel_rvalid = tgt2csb_valid[i];
                sel_wrc    = tgt2csb_wr_complete[i];
                sel_rdata  = tgt2csb_data[32*i +: 32];
            end
        end
    end

    // Bridge FSM with registered APB and CSB outputs.
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state_q   <= StIdle;
            tgt_q     <= '0;
            to_cnt_q  <= '0;
            skip_q    <= 1'b0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            valid_q   <= '0;
            addr_q    <= '0;
            wdat_q    <= 32'h0;
            write_q   <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            // Blocks a stale access phase in the first idle cycle after DONE.
            skip_q    <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (psel && penable && !skip_q) begin
                        addr_q  <= paddr[CSB_AW+1:2];
                        wdat_q  <= pwdata;
                        write_q <= pwrite;
                        tgt_q   <= sel;
                        if (!in_range) begin
                            state_q   <= StDone;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= 32'h0;
                        end else begin
                            state_q  <= StReq;
                            valid_q  <= ONE_HOT0 << sel;
                            to_cnt_q <= '0;
                        end
                    end
                end
                StReq: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (sel_ready && write_q && !NPOSTED) begin
                        // Posted write completes on acceptance.
                        valid_q  <= '0;
                        state_q  <= StDone;
                        pready_q <= 1'b1;
                        prdata_q <= 32'h0;
                    end else if (to_hit) begin
                        valid_q   <= '0;
                        state_q   <= StDone;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= 32'hFFFF_FFFF;
                    end else if (sel_ready) begin
                        valid_q <= '0;
                        state_q <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (!write_q && sel_rvalid) begin
                        state_q  <= StDone;
                        pready_q <= 1'b1;
                        prdata_q <= sel_rdata;
                    end else if (write_q && sel_wrc) begin
                        state_q  <= StDone;
                        pready_q <= 1'b1;
                        prdata_q <= 32'h0;
                    end else if (to_hit) begin
                        state_q   <= StDone;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= 32'hFFFF_FFFF;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign prdata          = prdata_q;
    assign pready          = pready_q;
    assign pslverr         = pslverr_q;
    assign csb2tgt_valid   = valid_q;
    assign csb2tgt_addr    = addr_q;
    assign csb2tgt_wdat    = wdat_q;
    assign csb2tgt_write   = write_q;
    assign csb2tgt_nposted = write_q & NPOSTED;

endmodule

// File: tb/tb_nvdla_apb2csb_mt.sv
// Directed bench for nvdla_apb2csb_mt: a 3-target non-posted instance with a short
// timeout, and a 2-target posted-write instance sharing the APB bus signals.
module tb_nvdla_apb2csb_mt;

    logic        clk = 1'b0;
    logic        prstn;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata;

    logic [31:0] prdata_a, wdat_a;
    logic        pready_a, pslverr_a, write_a, nposted_a;
    logic [2:0]  valid_a, ready_a, rvalid_a, wrc_a;
    logic [15:0] addr_a;
    logic [95:0] rdata_a;

    logic [31:0] prdata_b, wdat_b;
    logic        pready_b, pslverr_b, write_b, nposted_b;
    logic [1:0]  valid_b, ready_b, rvalid_b, wrc_b;
    logic [15:0] addr_b;
    logic [63:0] rdata_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nvdla_apb2csb_mt #(
        .NUM_TGT(3), .CSB_AW(16), .SEL_LSB(18), .NPOSTED_WR(1), .TIMEOUT(8), .TO_W(10)
    ) dut_a (
        .pclk(clk), .prstn(prstn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .csb2tgt_valid(valid_a), .csb2tgt_ready(ready_a),
        .csb2tgt_addr(addr_a), .csb2tgt_wdat(wdat_a), .csb2tgt_write(write_a),
        .csb2tgt_nposted(nposted_a), .tgt2csb_valid(rvalid_a), .tgt2csb_data(rdata_a),
        .tgt2csb_wr_complete(wrc_a)
    );

    nvdla_apb2csb_mt #(
        .NUM_TGT(2), .CSB_AW(16), .SEL_LSB(18), .NPOSTED_WR(0), .TIMEOUT(1023), .TO_W(10)
    ) dut_b (
        .pclk(clk), .prstn(prstn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .csb2tgt_valid(valid_b), .csb2tgt_ready(ready_b),
        .csb2tgt_addr(addr_b), .csb2tgt_wdat(wdat_b), .csb2tgt_write(write_b),
        .csb2tgt_nposted(nposted_b), .tgt2csb_valid(rvalid_b), .tgt2csb_data(rdata_b),
        .tgt2csb_wr_complete(wrc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Setup + access phase; returns at the sample point of the cycle after c0.
    task automatic apb_start(input logic to_b, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
        psel_a  = !to_b;
        psel_b  = to_b;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        tick();
        penable = 1'b1;
        tick();
    endtask

    task automatic apb_end();
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        prstn = 1'b0;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        ready_a = '0; rvalid_a = '0; wrc_a = '0; rdata_a = '0;
        ready_b = '0; rvalid_b = '0; wrc_b = '0; rdata_b = '0;
        tick();
        tick();
        chk("rst_pready", {31'h0, pready_a}, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr_a}, 32'h0);
        chk("rst_valid", {29'h0, valid_a}, 32'h0);
        chk("rst_prdata", prdata_a, 32'h0);
        chk("rst_addr", {16'h0, addr_a}, 32'h0);
        prstn = 1'b1;
        tick();

        // Read tgt1; a response in the acceptance cycle must be ignored.
        apb_start(1'b0, 1'b0, 32'h0004_0010, 32'h0);
        chk("rd1_valid", {29'h0, valid_a}, 32'h2);
        chk("rd1_addr", {16'h0, addr_a}, 32'h0004);
        chk("rd1_write", {31'h0, write_a}, 32'h0);
        ready_a = 3'b010;
        rvalid_a = 3'b010;
        rdata_a[63:32] = 32'hDEAD_0000;
        tick();
        chk("rd1_c2_pready", {31'h0, pready_a}, 32'h0);
        chk("rd1_c2_valid", {29'h0, valid_a}, 32'h0);
        ready_a = '0;
        rvalid_a = 3'b011;
        rdata_a[31:0] = 32'hBAD0_0000;
        rdata_a[63:32] = 32'hCAFE_0001;
        tick();
        chk("rd1_c3_pready", {31'h0, pready_a}, 32'h1);
        chk("rd1_c3_pslverr", {31'h0, pslverr_a}, 32'h0);
        chk("rd1_c3_prdata", prdata_a, 32'hCAFE_0001);
        rvalid_a = '0;
        apb_end();
        tick();
        chk("rd1_pready_drop", {31'h0, pready_a}, 32'h0);
        chk("rd1_prdata_hold", prdata_a, 32'hCAFE_0001);

        // Decode error: tgt field 3 with NUM_TGT=3.
        apb_start(1'b0, 1'b0, 32'h000C_0000, 32'h0);
        chk("dec_pready", {31'h0, pready_a}, 32'h1);
        chk("dec_pslverr", {31'h0, pslverr_a}, 32'h1);
        chk("dec_prdata", prdata_a, 32'h0);
        chk("dec_valid", {29'h0, valid_a}, 32'h0);
        apb_end();
        tick();
        chk("dec_pslverr_drop", {31'h0, pslverr_a}, 32'h0);
        chk("dec_pready_drop", {31'h0, pready_a}, 32'h0);

        // Non-posted write tgt0; completion 5 cycles after accept, stray wr_complete[1].
        apb_start(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
        chk("wr_valid", {29'h0, valid_a}, 32'h1);
        chk("wr_write", {31'h0, write_a}, 32'h1);
        chk("wr_nposted", {31'h0, nposted_a}, 32'h1);
        chk("wr_wdat", wdat_a, 32'h1234_5678);
        chk("wr_addr", {16'h0, addr_a}, 32'h0008);
        ready_a = 3'b001;
        for (int k = 2; k <= 6; k++) begin
            tick();
            ready_a = '0;
            chk("wr_wait_pready", {31'h0, pready_a}, 32'h0);
            wrc_a = (k == 3) ? 3'b010 : ((k == 6) ? 3'b001 : 3'b000);
        end
        tick();
        wrc_a = '0;
        chk("wr_pready", {31'h0, pready_a}, 32'h1);
        chk("wr_pslverr", {31'h0, pslverr_a}, 32'h0);
        apb_end();
        tick();
        chk("wr_single_pready", {31'h0, pready_a}, 32'h0);

        // Read timeout on tgt2: target never accepts.
        apb_start(1'b0, 1'b0, 32'h0008_0040, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            chk("to_pending_valid", {29'h0, valid_a}, 32'h4);
            chk("to_pending_pready", {31'h0, pready_a}, 32'h0);
            tick();
        end
        chk("to_pready", {31'h0, pready_a}, 32'h1);
        chk("to_pslverr", {31'h0, pslverr_a}, 32'h1);
        chk("to_prdata", prdata_a, 32'hFFFF_FFFF);
        chk("to_valid_drop", {29'h0, valid_a}, 32'h0);
        rvalid_a = 3'b100;
        rdata_a[95:64] = 32'h5555_5555;
        apb_end();
        tick();
        rvalid_a = '0;
        chk("late_rsp_pready", {31'h0, pready_a}, 32'h0);
        chk("late_rsp_prdata", prdata_a, 32'hFFFF_FFFF);

        // Fresh read of tgt2 after the timeout.
        apb_start(1'b0, 1'b0, 32'h0008_0040, 32'h0);
        ready_a = 3'b100;
        tick();
        ready_a = '0;
        rvalid_a = 3'b100;
        rdata_a[95:64] = 32'h1357_2468;
        tick();
        rvalid_a = '0;
        chk("fresh_pready", {31'h0, pready_a}, 32'h1);
        chk("fresh_prdata", prdata_a, 32'h1357_2468);
        chk("fresh_pslverr", {31'h0, pslverr_a}, 32'h0);
        apb_end();
        tick();

        // Response on the last allowed cycle: completion wins over timeout.
        apb_start(1'b0, 1'b0, 32'h0008_0040, 32'h0);
        ready_a = 3'b100;
        for (int k = 2; k <= 8; k++) begin
            tick();
            ready_a = '0;
            chk("edge_wait_pready", {31'h0, pready_a}, 32'h0);
        end
        rvalid_a = 3'b100;
        rdata_a[95:64] = 32'h600D_0008;
        tick();
        rvalid_a = '0;
        chk("edge_pready", {31'h0, pready_a}, 32'h1);
        chk("edge_pslverr", {31'h0, pslverr_a}, 32'h0);
        chk("edge_prdata", prdata_a, 32'h600D_0008);
        apb_end();
        tick();

        // Reset while waiting for a response.
        apb_start(1'b0, 1'b0, 32'h0000_0100, 32'h0);
        ready_a = 3'b001;
        tick();
        ready_a = '0;
        prstn = 1'b0;
        tick();
        chk("mrst_pready", {31'h0, pready_a}, 32'h0);
        chk("mrst_prdata", prdata_a, 32'h0);
        chk("mrst_valid", {29'h0, valid_a}, 32'h0);
        chk("mrst_pslverr", {31'h0, pslverr_a}, 32'h0);
        prstn = 1'b1;
        apb_end();
        tick();
        chk("mrst_no_pready", {31'h0, pready_a}, 32'h0);
        apb_start(1'b0, 1'b0, 32'h0000_0100, 32'h0);
        chk("post_rst_valid", {29'h0, valid_a}, 32'h1);
        ready_a = 3'b001;
        tick();
        ready_a = '0;
        rvalid_a = 3'b001;
        rdata_a[31:0] = 32'hA5A5_0000;
        tick();
        rvalid_a = '0;
        chk("post_rst_pready", {31'h0, pready_a}, 32'h1);
        chk("post_rst_prdata", prdata_a, 32'hA5A5_0000);
        apb_end();
        tick();

        // Posted write on the NPOSTED_WR=0 instance.
        apb_start(1'b1, 1'b1, 32'h0000_0030, 32'hFEED_BEEF);
        chk("pw_valid", {30'h0, valid_b}, 32'h1);
        chk("pw_nposted", {31'h0, nposted_b}, 32'h0);
        chk("pw_write", {31'h0, write_b}, 32'h1);
        chk("pw_wdat", wdat_b, 32'hFEED_BEEF);
        chk("pw_a_idle", {29'h0, valid_a}, 32'h0);
        ready_b = 2'b01;
        tick();
        ready_b = '0;
        chk("pw_pready", {31'h0, pready_b}, 32'h1);
        chk("pw_pslverr", {31'h0, pslverr_b}, 32'h0);
        chk("pw_valid_drop", {30'h0, valid_b}, 32'h0);
        apb_end();
        wrc_b = 2'b01;
        tick();
        wrc_b = '0;
        chk("pw_late_wrc", {31'h0, pready_b}, 32'h0);
        apb_start(1'b1, 1'b0, 32'h0000_0030, 32'h0);
        ready_b = 2'b01;
        tick();
        ready_b = '0;
        rvalid_b = 2'b01;
        rdata_b[31:0] = 32'h0000_BEEF;
        tick();
        rvalid_b = '0;
        chk("pw_rd_pready", {31'h0, pready_b}, 32'h1);
        chk("pw_rd_prdata", prdata_b, 32'h0000_BEEF);
        apb_end();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nvdla_apb2csb_mt.md
Name: nvdla_apb2csb_mt

Overview:
Parametrised APB-to-CSB bridge: the successor to the single-target apb2csb. It fans one APB slave port out to NUM_TGT CSB targets, decoded from upper paddr bits. It adds tracking of non-posted writes through wr_complete, a response timeout, and APB error signalling via pslverr. It sits between the SoC APB fabric and one or more NV_nvdla CSB ports, clocked by the CSB clock.

Parameters:
NUM_TGT, 2, number of CSB targets (1..8)
CSB_AW, 16, CSB word-address width; csb addr = paddr[CSB_AW+1:2]
SEL_LSB, 18, lowest paddr bit of target-select field; field width SEL_W = max(1, clog2(NUM_TGT))
NPOSTED_WR, 1, 1: writes issued non-posted and wait for wr_complete; 0: writes posted
TIMEOUT, 1023, cycles allowed in REQ+WAIT_RSP before error; 0 disables
TO_W, 10, timeout counter width (must hold TIMEOUT)

Ports:
pclk  in  1  clock
prstn  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  32  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready, one-cycle pulse
pslverr  out  1  APB error, valid with pready
csb2tgt_valid  out  NUM_TGT  per-target request valid (one-hot or zero)
csb2tgt_ready  in  NUM_TGT  per-target request ready
csb2tgt_addr  out  CSB_AW  shared request word address
csb2tgt_wdat  out  32  shared write data
csb2tgt_write  out  1  shared write flag
csb2tgt_nposted  out  1  shared non-posted flag
tgt2csb_valid  in  NUM_TGT  per-target read-response valid
tgt2csb_data  in  32*NUM_TGT  read data; target i at [32*i+31:32*i]
tgt2csb_wr_complete  in  NUM_TGT  per-target non-posted write completion

Behaviour:
- Single clock, synchronous active-low reset. On reset all outputs are 0, FSM = IDLE, timeout counter = 0. Reset mid-transaction abandons it; no pready is issued.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: on psel&penable, latch addr/wdat/write/tgt = paddr[SEL_LSB +: SEL_W].
  - If tgt >= NUM_TGT -> DONE with err=1, prdata=0, no CSB request.
  - Otherwise -> REQ; counter cleared.
- REQ: csb2tgt_valid[tgt]=1; shared fields are held stable. csb2tgt_nposted = write & NPOSTED_WR.
  - On csb2tgt_ready[tgt]: a read, or a write with NPOSTED_WR=1, -> WAIT_RSP; a posted write -> DONE with err=0.
  - Valid deasserts the cycle after acceptance.
- WAIT_RSP:
  - Read completes on tgt2csb_valid[tgt]; tgt2csb_data slice is captured into prdata -> DONE.
  - Write completes on tgt2csb_wr_complete[tgt] -> DONE, prdata=0.
  - Response can arrive no earlier than the cycle after acceptance; a response in the acceptance cycle is ignored.
- Timeout:
  - Counter increments each cycle in REQ/WAIT_RSP.
  - When counter == TIMEOUT-1 and no completion occurs that cycle -> DONE with err=1 and prdata=32'hFFFF_FFFF. csb2tgt_valid drops immediately, even if unaccepted.
  - Completion and timeout in the same cycle: completion wins.
- DONE: pready=1, pslverr=err for exactly one cycle -> IDLE. prdata holds until the next capture. pslverr returns to 0 with pready.
- IDLE ignores psel&penable in the cycle DONE exits; a new transfer is taken only on a fresh access phase, as APB guarantees.
- Responses or completions from non-selected targets, or arriving outside WAIT_RSP (including late ones after a timeout), are ignored. There is no stray-response side effect.
- If psel drops mid-transaction (master protocol violation), the CSB transaction still completes and the pready pulse is issued regardless.
- Latency from first access-phase cycle (c0), with ready=1 at first valid and response 1 cycle after acceptance:
  - Read: pready at c3.
  - Posted write: pready at c2.
  - Decode error: pready at c1.
- One transaction outstanding at most. There is no pipelining across APB transfers.

Test Plan:
- Read tgt1 (paddr=0x0004_0010, NUM_TGT=2): csb2tgt_valid=2'b10, addr=0x0004; ready at c1, tgt2csb_valid[1] at c2 with data 0xCAFE_0001 -> pready at c3, prdata=0xCAFE_0001, pslverr=0.
- Non-posted write tgt0 (paddr=0x20, pwdata=0x1234_5678): nposted=1, write=1, wdat=0x1234_5678. wr_complete[0] 5 cycles after accept -> single pready, pslverr=0; wr_complete[1] pulse during wait is ignored.
- NPOSTED_WR=0 write: nposted=0, pready the cycle after ready. A later wr_complete[0] has no effect on the next read.
- Decode error with NUM_TGT=3, paddr[19:18]=3 -> no csb2tgt_valid, pready at c1 with pslverr=1, prdata=0.
- Timeout with TIMEOUT=8, target never responds to read -> pready 8 cycles after REQ entry, pslverr=1, prdata=0xFFFF_FFFF. A response one cycle later is ignored and the next read returns fresh data. Repeat with response exactly on cycle 8 -> completion wins, pslverr=0.
- Reset asserted while in WAIT_RSP -> next cycle: all outputs 0, no pready. A following read completes normally.
